// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 demultiplexer.
package demux_pkg;
    localparam int DEMUX_NOUT  = 8;
    localparam int DEMUX_SEL_W = 3;

    typedef logic [DEMUX_SEL_W-1:0] sel_t;
endpackage

// File: rtl/dec_3to8.sv
// 3-to-8 one-hot decoder gating a WIDTH-bit data lane onto the selected output lane.
module dec_3to8
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    output logic [DEMUX_NOUT*WIDTH-1:0] y,
    input  logic [WIDTH-1:0]            i,
    input  sel_t                        s
);

    logic [DEMUX_NOUT-1:0] onehot;

    always_comb begin
        onehot = '0;
        onehot[s] = 1'b1;
    end

    // Each lane is the data ANDed with its replicated one-hot bit, so unselected lanes are zero.
    for (genvar k = 0; k < DEMUX_NOUT; k++) begin : g_lane
        assign y[k*WIDTH +: WIDTH] = i & {WIDTH{onehot[k]}};
    end

endmodule

// File: rtl/demux_1x8_sync.sv
// 1-to-8 demultiplexer with optional output register.
// Define DEMUX_1X8_OUT_REG_EN for the registered (1-cycle latency) build; otherwise y is combinational.
module demux_1x8_sync
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    output logic [DEMUX_NOUT*WIDTH-1:0] y,
    input  logic [WIDTH-1:0]            i,
    input  sel_t                        s,
    input  logic                        clk,
    input  logic                        rst
);

    logic [DEMUX_NOUT*WIDTH-1:0] y_p0;

    dec_3to8 #(
        .WIDTH(WIDTH)
    ) u_dec (
        .y(y_p0),
        .i(i),
        .s(s)
    );

`ifdef DEMUX_1X8_OUT_REG_EN
    logic [DEMUX_NOUT*WIDTH-1:0] y_p1;

    // p0 -> p1: decoded lanes registered; reset wins over data.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_p1 <= '0;
        end else begin
            y_p1 <= y_p0;
        end
    end

    assign y = y_p1;
`else
    // Clock and reset are kept on the port list but have no effect in this build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign y = y_p0;
`endif

endmodule

// File: tb/tb_demux_1x8_sync.sv
// Self-checking bench for demux_1x8_sync (WIDTH=1 and WIDTH=4), registered or combinational build.
module tb_demux_1x8_sync;
    import demux_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  iw;
    logic [0:0]  i1;
    sel_t        s1;
    logic [7:0]  y1;
    logic [3:0]  i4;
    sel_t        s4;
    logic [31:0] y4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // The connection keeps only the LSB of the wide driver.
    assign i1 = iw[0:0];

    demux_1x8_sync #(.WIDTH(1)) dut1 (.y(y1), .i(i1), .s(s1), .clk(clk), .rst(rst));
    demux_1x8_sync #(.WIDTH(4)) dut4 (.y(y4), .i(i4), .s(s4), .clk(clk), .rst(rst));

`ifdef DEMUX_1X8_OUT_REG_EN
    localparam bit REG_BUILD = 1'b1;
`else
    localparam bit REG_BUILD = 1'b0;
`endif

    typedef struct {
        string      name;
        logic       r;
        logic [7:0] iw;
        logic [2:0] s;
        logic [7:0] exp_reg;
        logic [7:0] exp_comb;
    } vec_t;

    vec_t vecs[$];

    // Reference: lane k holds the data when k equals the select, else zero; reset only matters when registered.
    function automatic logic [31:0] ref_y(input int width, input logic [3:0] din,
                                          input logic [2:0] sel, input logic r);
        logic [31:0] res;
        res = '0;
        if (!(REG_BUILD && r)) begin
            for (int k = 0; k < 8; k++) begin
                for (int b = 0; b < width; b++) begin
                    res[k*width + b] = (k == int'(sel)) ? din[b] : 1'b0;
                end
            end
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive between edges, then sample 1 time unit after the rising edge.
    task automatic apply(input logic r, input logic [7:0] w, input logic [2:0] sel);
        @(negedge clk);
        rst = r;
        iw  = w;
        s1  = sel;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        iw  = 8'h00;
        s1  = 3'd0;
        i4  = 4'h0;
        s4  = 3'd0;

        // Reset with live data, then release.
        vecs.push_back('{"reset0", 1'b1, 8'h01, 3'd5, 8'h00, 8'h20});
        vecs.push_back('{"reset1", 1'b1, 8'h01, 3'd5, 8'h00, 8'h20});
        vecs.push_back('{"reset_rel", 1'b0, 8'h01, 3'd5, 8'h20, 8'h20});
        for (int k = 0; k < 8; k++) begin
            logic [7:0] oh;
            oh = 8'h01 << k;
            vecs.push_back('{"sweep", 1'b0, 8'h01, 3'(k), oh, oh});
        end
        for (int k = 0; k < 8; k++)
            vecs.push_back('{"zero", 1'b0, 8'h00, 3'(k), 8'h00, 8'h00});
        vecs.push_back('{"trunc_fa", 1'b0, 8'hFA, 3'd3, 8'h00, 8'h00});
        vecs.push_back('{"trunc_05", 1'b0, 8'h05, 3'd3, 8'h08, 8'h08});
        vecs.push_back('{"trunc_10", 1'b0, 8'h10, 3'd3, 8'h00, 8'h00});
        vecs.push_back('{"mid_pre", 1'b0, 8'h01, 3'd7, 8'h80, 8'h80});
        vecs.push_back('{"mid_rst", 1'b1, 8'h01, 3'd7, 8'h00, 8'h80});
        vecs.push_back('{"mid_post", 1'b0, 8'h01, 3'd7, 8'h80, 8'h80});

        foreach (vecs[n]) begin
            apply(vecs[n].r, vecs[n].iw, vecs[n].s);
            check(vecs[n].name, {24'h0, y1}, {24'h0, REG_BUILD ? vecs[n].exp_reg : vecs[n].exp_comb});
        end

        // WIDTH=4 directed case.
        @(negedge clk);
        rst = 1'b0;
        i4  = 4'hA;
        s4  = 3'd2;
        #1;
        if (!REG_BUILD) check("w4_comb_same_step", y4, 32'h0000_0A00);
        @(posedge clk);
        #1;
        check("w4_a_s2", y4, 32'h0000_0A00);

        // Simultaneous change of data and select takes effect together.
        apply(1'b0, 8'h00, 3'd1);
        check("both_chg0", {24'h0, y1}, 32'h0);
        apply(1'b0, 8'h01, 3'd6);
        check("both_chg1", {24'h0, y1}, 32'h40);

        // Randomized traffic against the lane-level reference.
        for (int n = 0; n < 300; n++) begin
            logic       r;
            logic [7:0] w;
            logic [2:0] sa;
            logic [3:0] d4;
            logic [2:0] sb;
            r  = ($urandom_range(0, 15) == 0);
            w  = 8'($urandom);
            sa = 3'($urandom);
            d4 = 4'($urandom);
            sb = 3'($urandom);
            @(negedge clk);
            rst = r;
            iw  = w;
            s1  = sa;
            i4  = d4;
            s4  = sb;
            @(posedge clk);
            #1;
            check("rand_w1", {24'h0, y1}, ref_y(1, {3'b0, w[0]}, sa, r));
            check("rand_w4", y4, ref_y(4, d4, sb, r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
